mem_responder: RTL and testbench

Multi-cycle data-memory responder: the memory-side end of the CPU's load/store interface. It accepts one request at a time over a valid/ready handshake and holds a byte-maskable word array. It inserts a fixed number of wait states, then returns exactly one response pulse. It replaces the zero-latency data memory when the datapath is moved to a stall-on-memory pipeline.

---
 rtl/mem_responder_pkg.sv | 36 +++
 rtl/mem_resp_array.sv | 42 ++++
 rtl/mem_responder.sv | 111 +++++++++++
 tb/tb_mem_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
//   state_t    : FSM encoding (IDLE=0, WAIT=1, RESP=2)
//   BE_*       : byte-enable patterns with alignment rules
//   mem_req_t  : one latched load/store request
//   req_err()  : rejection check on a request
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [3:0]  be;
  } mem_req_t;

  // Out-of-range, empty mask, or a word/half access that is not naturally aligned.
  function automatic logic req_err(input logic [31:0] addr, input logic [3:0] be,
                                   input int unsigned aw);
    logic oor;
    oor = (addr >> aw) != 32'd0;
    return oor
        || (be == 4'b0000)
        || ((be == BE_WORD) && (addr[1:0] != 2'b00))
        || (((be == BE_HALF_LO) || (be == BE_HALF_HI)) && addr[0]);
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Byte-maskable word array for mem_responder.
//   clk, reset : clock, synchronous active-high clear of every word and rdata
//   commit     : the edge that finalises a transaction
//   write, err : kind of the committing request; err suppresses the write
//   word_addr  : word index
//   wdata, be  : store data and per-lane enables
//   rdata      : registered load data, 0 after stores and errors
module mem_resp_array
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  commit,
  input  logic                  write,
  input  logic                  err,
  input  logic [ADDR_WIDTH-3:0] word_addr,
  input  logic [31:0]           wdata,
  input  logic [3:0]            be,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else if (commit) begin
      // Loads return the whole word regardless of be; lane picking is the CPU's job.
      if (write || err) rdata <= '0;
      else              rdata <= mem[word_addr];
      if (write && !err)
        for (int l = 0; l < 4; l++)
          if (be[l]) mem[word_addr][8*l +: 8] <= wdata[8*l +: 8];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store at a time over
// valid/ready, waits WAIT_CYCLES cycles, then strobes exactly one response.
//   clk, reset                 : clock, synchronous active-high reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_addr/wdata/write/be    : request payload, held stable until accepted
//   resp_valid                 : one-cycle response strobe, no backpressure
//   resp_rdata, resp_err       : response payload, held until the next commit
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_write,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t   state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  mem_req_t req_q, cur;
  logic     accept, commit, cur_err;

  // With WAIT_CYCLES=0 the commit lands on the accept edge itself, so the
  // committing request must come straight from the ports while in IDLE.
  always_comb begin
    if (state == IDLE) begin
      cur.addr  = req_addr;
      cur.wdata = req_wdata;
      cur.write = req_write;
      cur.be    = req_be;
    end else begin
      cur = req_q;
    end
  end

  assign cur_err = req_err(cur.addr, cur.be, ADDR_WIDTH);
  assign accept  = (state == IDLE) && req_valid;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    commit     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_LOAD;
          end else begin
            state_nxt = RESP;
            commit    = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      req_q    <= '0;
      resp_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) req_q    <= cur;
      if (commit) resp_err <= cur_err;
    end
  end

  mem_resp_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk       (clk),
    .reset     (reset),
    .commit    (commit),
    .write     (cur.write),
    .err       (cur_err),
    .word_addr (cur.addr[ADDR_WIDTH-1:2]),
    .wdata     (cur.wdata),
    .be        (cur.be),
    .rdata     (resp_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes the expected response
// (data, error, cycle) into a queue; a monitor pops and compares on every
// resp_valid. A second instance with WAIT_CYCLES=0 checks the zero-wait path.
module tb_mem_responder;

  localparam int AW = 12;
  localparam int W  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_write = 1'b0;
  logic [3:0]  req_be = 4'hF;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        z_valid = 1'b0;
  logic        z_ready;
  logic [31:0] z_addr = '0, z_wdata = '0;
  logic        z_write = 1'b0;
  logic [3:0]  z_be = 4'hF;
  logic        z_rvalid;
  logic [31:0] z_rdata;
  logic        z_err;

  mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err));

  mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(z_valid), .req_ready(z_ready),
    .req_addr(z_addr), .req_wdata(z_wdata), .req_write(z_write), .req_be(z_be),
    .resp_valid(z_rvalid), .resp_rdata(z_rdata), .resp_err(z_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          at;
  } exp_t;
  exp_t sb[$];

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: every response strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_cycle", cyc, e.at);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("resp_rdata", resp_rdata, e.rd);
      end
    end
  end

  // Issue one request, wait (bounded) for accept, record the expected response.
  task automatic xact(input logic [31:0] a, input logic [31:0] d, input logic w,
                      input logic [3:0] be, input logic e_err, input logic [31:0] e_rd,
                      input bit push, output int acc);
    bit got;
    got = 0;
    acc = -1;
    req_addr = a; req_wdata = d; req_write = w; req_be = be; req_valid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1;
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    else begin
      acc = cyc;
      if (push) sb.push_back('{err: e_err, rd: e_rd, at: cyc + W + 1});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    chk("drain_pending", sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  // Zero-wait instance: response must be in the cycle right after accept.
  task automatic z_xact(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic [3:0] be, input logic [31:0] e_rd);
    z_addr = a; z_wdata = d; z_write = w; z_be = be; z_valid = 1'b1;
    @(negedge clk);
    chk("z_ready_idle", {31'd0, z_ready}, 32'd1);
    chk("z_no_resp_at_accept", {31'd0, z_rvalid}, 32'd0);
    @(posedge clk); #1;
    z_valid = 1'b0;
    @(negedge clk);
    chk("z_resp_valid", {31'd0, z_rvalid}, 32'd1);
    chk("z_resp_err", {31'd0, z_err}, 32'd0);
    chk("z_resp_rdata", z_rdata, e_rd);
    @(negedge clk);
    chk("z_single_pulse", {31'd0, z_rvalid}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int t0, t1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic store/load, partial-lane store
    xact(32'h10, 32'h1234_5678, 1, 4'hF, 0, 32'h0, 1, t0); drain();
    xact(32'h10, 32'h0, 0, 4'hF, 0, 32'h1234_5678, 1, t0); drain();
    xact(32'h10, 32'hAABB_CCDD, 1, 4'b0100, 0, 32'h0, 1, t0); drain();
    xact(32'h10, 32'h0, 0, 4'hF, 0, 32'h12BB_5678, 1, t0); drain();

    // Rejected requests leave the array alone
    xact(32'h1000, 32'h0, 0, 4'hF, 1, 32'h0, 1, t0); drain();
    xact(32'h12, 32'hDEAD_BEEF, 1, 4'hF, 1, 32'h0, 1, t0); drain();
    xact(32'h10, 32'hDEAD_BEEF, 1, 4'b0000, 1, 32'h0, 1, t0); drain();
    xact(32'h11, 32'hDEAD_BEEF, 1, 4'b0011, 1, 32'h0, 1, t0); drain();
    xact(32'h10, 32'h0, 0, 4'hF, 0, 32'h12BB_5678, 1, t0); drain();

    // Aligned low-half store at byte 2 is legal; load with a narrow be returns the whole word
    xact(32'h12, 32'h9988_7766, 1, 4'b0011, 0, 32'h0, 1, t0); drain();
    xact(32'h10, 32'h0, 0, 4'b0001, 0, 32'h12BB_7766, 1, t0); drain();
    xact(32'h14, 32'h0BAD_CAFE, 1, 4'hF, 0, 32'h0, 1, t0); drain();

    // Back-to-back with req_valid held high
    req_addr = 32'h10; req_write = 1'b0; req_be = 4'hF; req_valid = 1'b1;
    t0 = -1;
    for (int i = 0; i < 40 && t0 < 0; i++) begin
      @(negedge clk);
      if (req_ready) t0 = cyc;
    end
    if (t0 < 0) chk("b2b_accept_timeout", 32'd0, 32'd1);
    else begin
      sb.push_back('{err: 1'b0, rd: 32'h12BB_7766, at: t0 + W + 1});
      @(posedge clk); #1;
      req_addr = 32'h14;
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        chk("b2b_ready_low", {31'd0, req_ready}, 32'd0);
      end
      @(negedge clk);
      chk("b2b_ready_again", {31'd0, req_ready}, 32'd1);
      chk("b2b_second_accept", cyc, t0 + 4);
      sb.push_back('{err: 1'b0, rd: 32'h0BAD_CAFE, at: cyc + W + 1});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();

    // Reset during WAIT drops the store; reset also clears the whole array
    xact(32'h20, 32'h5555_AAAA, 1, 4'hF, 0, 32'h0, 0, t1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    xact(32'h20, 32'h0, 0, 4'hF, 0, 32'h0, 1, t0); drain();
    xact(32'h10, 32'h0, 0, 4'hF, 0, 32'h0, 1, t0); drain();

    // Zero-wait build
    z_xact(32'h8, 32'hCAFE_F00D, 1, 4'hF, 32'h0);
    z_xact(32'h8, 32'h0, 0, 4'hF, 32'hCAFE_F00D);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1);
  end

endmodule
